// File: rtl/mdu_alu.sv
// mdu_alu: multicycle-datapath ALU with operand muxing, a registered result,
// and an iterative multiply/divide unit (shift-add multiply, restoring divide)
// that writes HI/LO.
// Optional build macro MDU_SIGNED_EN adds signed MULT (1010) and DIV (1011).
// Those reuse the unsigned iteration on operand magnitudes, and the signs are
// applied to the final values.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ALU only; start with a multiply/divide op launches the MDU
// MUL   | one multiplier bit per cycle, busy = 1
// DIV   | one quotient bit per cycle, busy = 1
// DONE  | hi/lo hold the fresh result, done = 1 for one cycle

`timescale 1ns/1ps

module mdu_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_src_a,
    input  logic [1:0]       alu_src_b,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [WIDTH-1:0] pc_out,
    input  logic [WIDTH-1:0] extended_constant,
    input  logic [3:0]       alu_operation,
    input  logic             start,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             overflow,
    output logic             zero_flag,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_NOTA  = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
`ifdef MDU_SIGNED_EN
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
`endif

    state_t state, state_next;

    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] sum, diff;

    logic             is_mul_op, is_div_op, signed_op, launch;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic [CNT_W-1:0] cnt;
    logic             op_signed, sign_a, sign_b, div_zero;
    logic             last_iter;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_next, mul_lo_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_hi_next, div_lo_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    // Operand selection for both the ALU and the MDU launch.
    always_comb begin
        op_a = alu_src_a ? reg_a : pc_out;
        case (alu_src_b)
            2'b00:   op_b = reg_b;
            2'b01:   op_b = WIDTH'(1);
            2'b10:   op_b = extended_constant;
            default: op_b = extended_constant << 2;
        endcase
    end

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    // Combinational ALU; overflow only meaningful for ADD/SUB.
    always_comb begin
        alu_result = '0;
        overflow   = 1'b0;
        case (alu_operation)
            OP_ADD: begin
                alu_result = sum;
                overflow   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = diff;
                overflow   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_NOR:  alu_result = ~(op_a | op_b);
            OP_NOTA: alu_result = ~op_a;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_result = '0;
        endcase
    end

    assign zero_flag = (alu_result == '0);

    // Registered result follows the ALU except while the MDU iterates.
    always_ff @(posedge clk) begin
        if (reset)
            alu_out <= '0;
        else if (!busy)
            alu_out <= alu_result;
    end

    // Launch decode; signed ops are reduced to magnitudes here.
    always_comb begin
        is_mul_op = (alu_operation == OP_MULTU);
        is_div_op = (alu_operation == OP_DIVU);
        signed_op = 1'b0;
        mag_a     = op_a;
        mag_b     = op_b;
`ifdef MDU_SIGNED_EN
        if (alu_operation == OP_MULT || alu_operation == OP_DIV) begin
            signed_op = 1'b1;
            is_mul_op = (alu_operation == OP_MULT);
            is_div_op = (alu_operation == OP_DIV);
            mag_a     = op_a[WIDTH-1] ? -op_a : op_a;
            mag_b     = op_b[WIDTH-1] ? -op_b : op_b;
        end
`endif
    end

    assign launch    = (state == IDLE) && start && (is_mul_op || is_div_op);
    assign last_iter = (cnt == CNT_W'(1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start && is_mul_op)
                    state_next = MUL;
                else if (start && is_div_op)
                    state_next = DIV;
            end
            MUL: begin
                busy = 1'b1;
                if (last_iter)
                    state_next = DONE;
            end
            DIV: begin
                busy = 1'b1;
                if (last_iter)
                    state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One iteration step of shift-add multiply and restoring divide.
    // The subtraction only needs WIDTH bits: when it is taken the result is
    // below the divisor and therefore fits.
    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
        div_shift   = {acc_hi, acc_lo[WIDTH-1]};
        div_ge      = (div_shift >= {1'b0, opnd});
        div_trial   = div_shift[WIDTH-1:0] - opnd;
        div_hi_next = div_ge ? div_trial : div_shift[WIDTH-1:0];
        div_lo_next = {acc_lo[WIDTH-2:0], div_ge};
    end

    // Final hi/lo values with sign correction for signed ops. Divide by zero
    // keeps the all-ones quotient; the remainder then already equals the dividend.
    always_comb begin
        prod = {mul_hi_next, mul_lo_next};
        if (op_signed && (sign_a ^ sign_b))
            prod = -prod;
        quo = div_lo_next;
        rem = div_hi_next;
        if (op_signed && (sign_a ^ sign_b) && !div_zero)
            quo = -quo;
        if (op_signed && sign_a)
            rem = -rem;
        if (state == MUL) begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end else begin
            fin_hi = rem;
            fin_lo = quo;
        end
    end

    // MDU datapath; hi/lo are written on the edge into DONE so they are
    // already valid while done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            cnt       <= '0;
            op_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div_zero  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else if (launch) begin
            acc_hi    <= '0;
            acc_lo    <= mag_a;
            opnd      <= mag_b;
            cnt       <= CNT_W'(WIDTH);
            op_signed <= signed_op;
            sign_a    <= op_a[WIDTH-1];
            sign_b    <= op_b[WIDTH-1];
            div_zero  <= (op_b == '0);
        end else if (state == MUL || state == DIV) begin
            acc_hi <= (state == MUL) ? mul_hi_next : div_hi_next;
            acc_lo <= (state == MUL) ? mul_lo_next : div_lo_next;
            cnt    <= cnt - CNT_W'(1);
            if (last_iter) begin
                hi <= fin_hi;
                lo <= fin_lo;
            end
        end
    end

endmodule

// File: tb/tb_mdu_alu.sv
// tb_mdu_alu: directed literal cases plus randomized traffic, checked every
// cycle against a cycle-count behavioural model of mdu_alu (WIDTH = 32).

`timescale 1ns/1ps

module tb_mdu_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [W-1:0]  reg_a, reg_b, pc_out, extended_constant;
    logic [3:0]    alu_operation;
    logic          start;
    logic [W-1:0]  alu_result, alu_out, hi, lo;
    logic          overflow, zero_flag, busy, done;

    int checks   = 0;
    int failures = 0;

    mdu_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_a(reg_a), .reg_b(reg_b), .pc_out(pc_out), .extended_constant(extended_constant),
        .alu_operation(alu_operation), .start(start), .alu_result(alu_result),
        .alu_out(alu_out), .hi(hi), .lo(lo), .overflow(overflow), .zero_flag(zero_flag),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] opnd_a();
        return alu_src_a ? reg_a : pc_out;
    endfunction

    function automatic logic [W-1:0] opnd_b();
        case (alu_src_b)
            2'd0:    return reg_b;
            2'd1:    return 32'd1;
            2'd2:    return extended_constant;
            default: return extended_constant * 4;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd12:   return ~(a | b);
            4'd3:    return ~a;
            4'd7:    return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 4'd2)      r = sa + sb;
        else if (op == 4'd6) r = sa - sb;
        else                 return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic logic is_mdu(input logic [3:0] op);
`ifdef MDU_SIGNED_EN
        return op inside {4'd8, 4'd9, 4'd10, 4'd11};
`else
        return op inside {4'd8, 4'd9};
`endif
    endfunction

    // phase = cycles since launch; 1..W busy, W+1 done, 0 idle
    int           m_phase = 0;
    bit           m_valid = 0;
    logic [W-1:0] m_alu_out, m_hi, m_lo, p_hi, p_lo;

    // Model update from the inputs seen at each rising edge.
    always @(posedge clk) begin
        logic [W-1:0] a, b;
        logic [63:0]  pr;
        logic signed [63:0] sa, sb, q, r;
        if (reset) begin
            m_alu_out = '0; m_hi = '0; m_lo = '0; m_phase = 0; m_valid = 1;
        end else if (m_valid) begin
            a = opnd_a();
            b = opnd_b();
            if (!(m_phase >= 1 && m_phase <= W))
                m_alu_out = ref_result(alu_operation, a, b);
            if (m_phase == 0) begin
                if (start && is_mdu(alu_operation)) begin
                    m_phase = 1;
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    if (alu_operation == 4'd8) begin
                        pr = 64'(a) * 64'(b);
                        p_hi = pr[63:32]; p_lo = pr[31:0];
                    end else if (alu_operation == 4'd10) begin
                        q = sa * sb;
                        p_hi = q[63:32]; p_lo = q[31:0];
                    end else if (b == 0) begin
                        p_hi = a; p_lo = '1;
                    end else if (alu_operation == 4'd9) begin
                        p_lo = a / b; p_hi = a % b;
                    end else begin
                        q = sa / sb; r = sa % sb;
                        p_lo = q[31:0]; p_hi = r[31:0];
                    end
                end
            end else if (m_phase == W) begin
                m_phase = W + 1; m_hi = p_hi; m_lo = p_lo;
            end else if (m_phase == W + 1) begin
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end
    end

    // Compare process: every output against the model, mid-cycle.
    always @(negedge clk) begin
        logic [W-1:0] ea, eb, er;
        if (m_valid) begin
            ea = opnd_a();
            eb = opnd_b();
            er = ref_result(alu_operation, ea, eb);
            chk("alu_result", alu_result, er);
            chk("zero_flag", zero_flag, (er == 0));
            chk("overflow", overflow, ref_ovf(alu_operation, ea, eb));
            chk("alu_out", alu_out, m_alu_out);
            chk("busy", busy, (m_phase >= 1 && m_phase <= W));
            chk("done", done, (m_phase == W + 1));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        alu_src_a = 1'b1; alu_src_b = 2'b00;
        reg_a = a; reg_b = b; alu_operation = op; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called just after the launch edge; done must appear in cycle W+1.
    task automatic wait_done(input string name, input logic [W-1:0] ehi, input logic [W-1:0] elo, input bit scramble);
        int n = 0;
        bit got = 0;
        while (!got && n < W + 8) begin
            @(negedge clk);
            n++;
            if (scramble && n == W) chk({name, "_alu_out_frozen"}, alu_out, 0);
            if (done) got = 1;
            else if (scramble) begin
                alu_operation = 4'd2; reg_a = $urandom; reg_b = $urandom;
            end
        end
        if (!got) chk({name, "_done_timeout"}, 0, 1);
        else begin
            chk({name, "_latency"}, n, W + 1);
            chk({name, "_hi"}, hi, ehi);
            chk({name, "_lo"}, lo, elo);
        end
    endtask

    task automatic rand_inputs();
        alu_src_a = 1'($urandom_range(0, 1));
        alu_src_b = 2'($urandom_range(0, 3));
        reg_a = $urandom;
        case ($urandom_range(0, 9))
            0:       reg_b = 0;
            1:       reg_b = reg_a;
            2:       reg_b = $urandom_range(1, 20);
            default: reg_b = $urandom;
        endcase
        pc_out = $urandom;
        extended_constant = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        if ($urandom_range(0, 2) == 0) alu_operation = 4'(8 + $urandom_range(0, 3));
        else                           alu_operation = 4'($urandom_range(0, 15));
        start = ($urandom_range(0, 3) == 0);
        reset = ($urandom_range(0, 399) == 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'b00;
        reg_a = '0; reg_b = '0; pc_out = '0; extended_constant = '0; alu_operation = 4'd0;
        tick(); tick();
        @(negedge clk);
        chk("rst_alu_out", alu_out, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        tick();

        alu_src_a = 1'b1; reg_a = 32'h7FFF_FFFF; alu_src_b = 2'b01; alu_operation = 4'd2;
        @(negedge clk);
        chk("add_result", alu_result, 32'h8000_0000);
        chk("add_ovf", overflow, 1);
        tick();
        @(negedge clk);
        chk("add_alu_out", alu_out, 32'h8000_0000);
        tick();

        alu_src_b = 2'b00; reg_a = 32'h1234; reg_b = 32'h1234; alu_operation = 4'd6;
        @(negedge clk);
        chk("sub_result", alu_result, 0);
        chk("sub_zero", zero_flag, 1);
        chk("sub_ovf", overflow, 0);
        tick();
        reg_a = 32'hFFFF_FFFF; reg_b = 32'd1; alu_operation = 4'd7;
        @(negedge clk);
        chk("slt_result", alu_result, 1);
        tick();

        launch(4'd8, 32'hFFFF_FFFF, 32'd2);
        wait_done("multu", 32'h1, 32'hFFFF_FFFE, 1);
        tick();
        launch(4'd9, 32'd100, 32'd7);
        wait_done("divu", 32'd2, 32'd14, 0);
        tick();
        launch(4'd9, 32'd55, 32'd0);
        wait_done("divu_zero", 32'd55, 32'hFFFF_FFFF, 0);
        tick();

        // second start mid-operation, then reset mid-operation
        launch(4'd8, 32'd5, 32'd6);
        repeat (4) tick();
        start = 1'b1; alu_operation = 4'd8; reg_a = 32'd9; reg_b = 32'd9;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        reset = 1'b0;
        tick();
        launch(4'd8, 32'd3, 32'd4);
        wait_done("multu_after_rst", 32'd0, 32'd12, 0);
        tick();

`ifdef MDU_SIGNED_EN
        launch(4'd11, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_signed", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        tick();
        launch(4'd10, 32'hFFFF_FFFD, 32'd4);
        wait_done("mult_signed", 32'hFFFF_FFFF, 32'hFFFF_FFF4, 0);
        tick();
`endif

        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            tick();
        end
        reset = 1'b0; start = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
